// File: rtl/keystroke_pkg.sv
// keystroke_ctrl shared constants and types.
// Opcodes, keystroke bit map and the FIFO entry layout.
package keystroke_pkg;

  localparam int MAX_LEN         = 32;
  localparam int MAX_LEN_BIT_LEN = 5;
  localparam int DB_CYCLES       = 4;
  localparam int FIFO_DEPTH      = 4;

  localparam logic [1:0] OP_ENTER  = 2'd0;
  localparam logic [1:0] OP_DELETE = 2'd1;
  localparam logic [1:0] OP_CLEAR  = 2'd2;
  localparam logic [1:0] OP_RUN    = 2'd3;

  localparam int KS_ENTER  = 8;
  localparam int KS_DELETE = 9;
  localparam int KS_CLEAR  = 10;
  localparam int KS_RUN    = 11;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] data;
  } cmd_t;

endpackage

// File: rtl/keystroke_if.sv
// Command handshake between keystroke_ctrl and core.
// The controller is the master; core is the slave.
interface keystroke_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    output cmd_ready
  );

endinterface

// File: rtl/key_debounce.sv
// Per-button debouncer fed from the synchronized input.
// Emits a one-cycle press pulse on an armed 0->1 flip.
module key_debounce
  import keystroke_pkg::*;
#(
  parameter int DB_CYCLES = 4
) (
  input  logic clk_raw,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_press;
  logic          r_armed;
  logic [1:0]    r_warm;
  logic          w_diff;
  logic          w_flip;

  assign w_diff = din ^ r_level;
  assign w_flip = w_diff &&
                  (r_cnt == CW'(DB_CYCLES - 1));

  // Arm only after din carries real data and
  // has been seen low, so a key held across
  // reset release never counts as a press.
  always_ff @(posedge clk_raw or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_armed <= 1'b0;
      r_warm  <= '0;
    end else begin
      r_warm  <= {r_warm[0], 1'b1};
      if (r_warm[1] && !din)
        r_armed <= 1'b1;
      r_press <= w_flip && din && r_armed;
      if (!w_diff || w_flip)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + CW'(1);
      if (w_flip)
        r_level <= din;
    end
  end

  assign level = r_level;
  assign press = r_press;

endmodule

// File: rtl/keystroke_ctrl.sv
// Keystroke input controller: sync, debounce, arbitrate,
// legality-check and queue commands for core.
module keystroke_ctrl
  import keystroke_pkg::*;
(
  input  logic                     clk_raw,
  input  logic                     rst_n,
  input  logic [11:0]              keystroke,
  keystroke_if.master              cmd,
  output logic [MAX_LEN_BIT_LEN:0] buf_len,
  output logic                     buf_full,
  output logic                     buf_empty,
  output logic                     err
);

  localparam int LW = MAX_LEN_BIT_LEN + 1;
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [11:0]   r_s1;
  logic [11:0]   r_s2;
  logic [7:0]    r_data;
  logic [LW-1:0] r_len;
  logic          r_err;
  logic [PW:0]   r_wptr;
  logic [PW:0]   r_rptr;
  cmd_t          r_mem [FIFO_DEPTH];

  logic [3:0]    w_level;
  logic [3:0]    w_press;
  logic [3:0]    w_evt;
  logic [3:0]    w_win;
  logic          w_multi;
  logic [1:0]    w_op;
  logic          w_any;
  logic          w_legal;
  logic [LW-1:0] w_len_nxt;
  logic [PW:0]   w_cnt;
  logic          w_ffull;
  logic          w_wr;
  logic          w_rd;
  logic          w_eset;
  logic          w_eclr;

  always_ff @(posedge clk_raw or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_data <= '0;
    end else begin
      r_s1   <= keystroke;
      r_s2   <= r_s1;
      r_data <= r_s2[7:0];
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_db
    key_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clk_raw (clk_raw),
      .rst_n   (rst_n),
      .din     (r_s2[KS_ENTER+i]),
      .level   (w_level[i]),
      .press   (w_press[i])
    );
  end

  assign w_evt   = w_press & w_level;
  assign w_multi = (w_evt & (w_evt - 4'd1)) != 4'd0;

  // Bit order is ENTER, DELETE, CLEAR, RUN.
  assign w_win[2] = w_evt[2];
  assign w_win[1] = w_evt[1] & ~w_evt[2];
  assign w_win[0] = w_evt[0] & ~|w_evt[2:1];
  assign w_win[3] = w_evt[3] & ~|w_evt[2:0];

  always_comb begin
    w_op      = OP_ENTER;
    w_any     = 1'b0;
    w_legal   = 1'b0;
    w_len_nxt = r_len;
    unique case (1'b1)
      w_win[2]: begin
        w_op      = OP_CLEAR;
        w_any     = 1'b1;
        w_legal   = 1'b1;
        w_len_nxt = '0;
      end
      w_win[1]: begin
        w_op      = OP_DELETE;
        w_any     = 1'b1;
        w_legal   = r_len != '0;
        w_len_nxt = r_len - LW'(1);
      end
      w_win[0]: begin
        w_op      = OP_ENTER;
        w_any     = 1'b1;
        w_legal   = r_len < LW'(MAX_LEN);
        w_len_nxt = r_len + LW'(1);
      end
      w_win[3]: begin
        w_op      = OP_RUN;
        w_any     = 1'b1;
        w_legal   = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_cnt   = r_wptr - r_rptr;
  assign w_ffull = w_cnt == (PW+1)'(FIFO_DEPTH);
  assign w_wr    = w_any & w_legal & ~w_ffull;
  assign w_rd    = cmd.cmd_valid & cmd.cmd_ready;
  assign w_eset  = w_multi | (w_any & ~w_wr);
  assign w_eclr  = w_wr & (w_op == OP_CLEAR);

  always_ff @(posedge clk_raw or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_len  <= '0;
      r_err  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        r_mem[i] <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr[PW-1:0]] <= '{op: w_op, data: r_data};
        r_wptr <= r_wptr + (PW+1)'(1);
        r_len  <= w_len_nxt;
      end
      if (w_rd)
        r_rptr <= r_rptr + (PW+1)'(1);
      r_err <= (r_err & ~w_eclr) | w_eset;
    end
  end

  assign cmd.cmd_valid = r_wptr != r_rptr;
  assign cmd.cmd_op    = r_mem[r_rptr[PW-1:0]].op;
  assign cmd.cmd_data  = r_mem[r_rptr[PW-1:0]].data;

  assign buf_len   = r_len;
  assign buf_full  = r_len == LW'(MAX_LEN);
  assign buf_empty = r_len == '0;
  assign err       = r_err;

endmodule

// File: tb/tb_keystroke_ctrl.sv
// Bench for keystroke_ctrl: directed steps plus random
// presses checked against a command-level reference model.
module tb_keystroke_ctrl;
  import keystroke_pkg::*;

  logic        clk_raw = 1'b0;
  logic        rst_n   = 1'b0;
  logic [11:0] keystroke = '0;
  logic [5:0]  buf_len;
  logic        buf_full;
  logic        buf_empty;
  logic        err;

  keystroke_if u_if ();

  keystroke_ctrl dut (
    .clk_raw   (clk_raw),
    .rst_n     (rst_n),
    .keystroke (keystroke),
    .cmd       (u_if),
    .buf_len   (buf_len),
    .buf_full  (buf_full),
    .buf_empty (buf_empty),
    .err       (err)
  );

  always #5 clk_raw = ~clk_raw;

  int         nvec = 0;
  int         nerr = 0;
  logic [9:0] exp_q [$];
  int         m_len = 0;
  bit         m_err = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, expv);
    end
  endtask

  // Command-level rules: pick the top-priority key, check
  // the buffer/FIFO limits, update length and sticky error.
  task automatic model(input logic [3:0] m,
                       input logic [7:0] d);
    int         n;
    logic [1:0] op;
    bit         legal;
    bit         seterr;
    bit         clr;
    n = $countones(m);
    if (n == 0) return;
    seterr = (n > 1);
    clr    = 1'b0;
    if (m[2])      op = OP_CLEAR;
    else if (m[1]) op = OP_DELETE;
    else if (m[0]) op = OP_ENTER;
    else           op = OP_RUN;
    if (op == OP_DELETE)     legal = (m_len > 0);
    else if (op == OP_ENTER) legal = (m_len < MAX_LEN);
    else                     legal = 1'b1;
    if (legal && exp_q.size() < FIFO_DEPTH) begin
      exp_q.push_back({op, d});
      if (op == OP_ENTER)  m_len = m_len + 1;
      if (op == OP_DELETE) m_len = m_len - 1;
      if (op == OP_CLEAR)  m_len = 0;
      clr = (op == OP_CLEAR);
    end else begin
      seterr = 1'b1;
    end
    m_err = (m_err && !clr) || seterr;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_len"},   buf_len,   m_len);
    chk({tag, "_full"},  buf_full,  m_len == MAX_LEN);
    chk({tag, "_empty"}, buf_empty, m_len == 0);
    chk({tag, "_err"},   err,       m_err);
  endtask

  task automatic press(input logic [3:0] m,
                       input logic [7:0] d,
                       input int hold,
                       input string tag);
    @(negedge clk_raw);
    keystroke = {m, d};
    model(m, d);
    repeat (hold) @(negedge clk_raw);
    keystroke = {4'b0000, d};
    repeat (14) @(negedge clk_raw);
    check_state(tag);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++)
      @(negedge clk_raw);
    @(negedge clk_raw);
    chk({tag, "_left"},  exp_q.size(), 0);
    chk({tag, "_valid"}, u_if.cmd_valid, 0);
  endtask

  always @(negedge clk_raw) begin
    if (rst_n && u_if.cmd_valid && u_if.cmd_ready) begin
      if (exp_q.size() == 0)
        chk("pop_unexpected", exp_q.size(), 1);
      else
        chk("pop", {u_if.cmd_op, u_if.cmd_data},
            exp_q.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] m;
    int         r;
    u_if.cmd_ready = 1'b0;

    repeat (3) @(negedge clk_raw);
    chk("rst_valid", u_if.cmd_valid, 0);
    chk("rst_op",    u_if.cmd_op,    0);
    chk("rst_data",  u_if.cmd_data,  0);
    check_state("rst");
    rst_n = 1'b1;
    repeat (5) @(negedge clk_raw);

    @(negedge clk_raw);
    keystroke = 12'h182;
    model(4'b0001, 8'h82);
    repeat (5) @(negedge clk_raw);
    keystroke = 12'h082;
    @(negedge clk_raw);
    chk("lat_early", u_if.cmd_valid, 0);
    @(negedge clk_raw);
    chk("lat_rise", u_if.cmd_valid, 1);
    chk("lat_op",   u_if.cmd_op,   OP_ENTER);
    chk("lat_data", u_if.cmd_data, 8'h82);
    check_state("first");
    repeat (10) @(negedge clk_raw);
    u_if.cmd_ready = 1'b1;
    drain("first");

    @(negedge clk_raw);
    keystroke = 12'h100;
    repeat (3) @(negedge clk_raw);
    keystroke = 12'h000;
    repeat (15) @(negedge clk_raw);
    chk("glitch_valid", u_if.cmd_valid, 0);
    check_state("glitch");

    press(4'b0100, 8'h00, 5, "clr0");
    drain("clr0");
    u_if.cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      press(4'b0001, 8'(8'h10 + i), 5, "ffull");
    chk("ffull_valid", u_if.cmd_valid, 1);
    u_if.cmd_ready = 1'b1;
    drain("ffull");

    press(4'b0100, 8'h01, 5, "clr1");
    drain("clr1");
    for (int i = 0; i < 33; i++)
      press(4'b0001, 8'($urandom), 5, "bfull");
    press(4'b0100, 8'hc3, 6, "clr2");
    drain("clr2");

    press(4'b0010, 8'h44, 5, "del0");
    press(4'b0101, 8'h66, 5, "multi");
    drain("multi");

    u_if.cmd_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      press(4'b0001, 8'(8'h20 + i), 5, "pre_rst");
    chk("pre_rst_valid", u_if.cmd_valid, 1);
    @(negedge clk_raw);
    #2 rst_n = 1'b0;
    keystroke = 12'h155;
    #1;
    chk("arst_valid", u_if.cmd_valid, 0);
    chk("arst_len",   buf_len,        0);
    chk("arst_empty", buf_empty,      1);
    exp_q.delete();
    m_len = 0;
    m_err = 1'b0;
    @(negedge clk_raw);
    rst_n = 1'b1;
    repeat (20) @(negedge clk_raw);
    chk("held_valid", u_if.cmd_valid, 0);
    check_state("held");
    keystroke = 12'h055;
    repeat (12) @(negedge clk_raw);
    u_if.cmd_ready = 1'b1;
    press(4'b0001, 8'h33, 5, "repress");
    drain("repress");

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 19);
      if (r < 10)      m = 4'b0001;
      else if (r < 14) m = 4'b0010;
      else if (r < 15) m = 4'b0100;
      else if (r < 18) m = 4'b1000;
      else             m = 4'(1 << $urandom_range(0, 3)) |
                           4'(1 << $urandom_range(0, 3));
      press(m, 8'($urandom), $urandom_range(4, 8), "rnd");
    end
    drain("rnd");

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/keystroke_ctrl.md
# keystroke_ctrl

Input controller between the board's raw `keystroke` vector and `core`. It synchronizes the switch and button inputs and debounces the four push buttons. Each accepted button press becomes one command in a small FIFO, which `core` drains over a valid/ready handshake. The controller tracks the text-buffer length against `max_len` and drops commands that would underflow or overflow the buffer, so `core` never sequences an illegal edit.

## Interface
- `max_len`, 32: capacity of the core's buffer in entries.
- `max_len_bit_len`, 5: log2(`max_len`); `buf_len` is `max_len_bit_len+1` bits wide.
- `db_cycles`, 4: number of stable cycles required before a button changes debounced state.
- `fifo_depth`, 4: command FIFO entries (power of two).

Ports:
- `clk_raw`  in  1: single clock; every flop is on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `keystroke`  in  12: [7:0] level switches (data); [8] ENTER, [9] DELETE, [10] CLEAR, [11] RUN buttons.
- `cmd_valid`  out  1: FIFO head is valid.
- `cmd_op`  out  2: head opcode.
- `cmd_data`  out  8: head switch snapshot.
- `cmd_ready`  in  1: core accepts the head.
- `buf_len`  out  `max_len_bit_len+1`: projected buffer length.
- `buf_full`  out  1: `buf_len == max_len`.
- `buf_empty`  out  1: `buf_len == 0`.
- `err`  out  1: sticky; set by any dropped command.

## Operation
- Synchronizer: all 12 bits pass through two flops (`s1`, `s2`).
- Debounce, per button:
  - Counter clears whenever `s2` equals the debounced state.
  - While they differ, the counter increments.
  - On the cycle the counter reaches `db_cycles-1` and they still differ, the debounced state flips and the counter clears.
  - A 0→1 flip produces a one-cycle `press` pulse.
- Press arbitration: if several `press` pulses fire in the same cycle, only the highest-priority one is considered and the others set `err`. Priority is CLEAR > DELETE > ENTER > RUN.
- Legality check at enqueue (projected length `buf_len`):
  - ENTER: legal if `buf_len < max_len`; `buf_len`+1.
  - DELETE: legal if `buf_len > 0`; `buf_len`-1.
  - CLEAR: always legal; `buf_len` := 0; clears `err` (CLEAR also setting `err` in the same cycle wins).
  - RUN: always legal; length unchanged.
- Illegal command or FIFO full: the command is not written, `buf_len` is unchanged, and `err` is set.
- FIFO entry is {op, `s2[7:0]` sampled in the flip cycle}.
- Opcodes: ENTER=0, DELETE=1, CLEAR=2, RUN=3.
- Dequeue: on `cmd_valid && cmd_ready` the head pops. Enqueue and dequeue in the same cycle are both performed and the count is unchanged. Enqueue while full is dropped even if a pop occurs that cycle.
- Pointers wrap modulo `fifo_depth`; one extra bit distinguishes full from empty.

## Timing
- Reset values:
  - `cmd_valid`=0, `cmd_op`=0, `cmd_data`=0.
  - `buf_len`=0, `buf_empty`=1, `buf_full`=0, `err`=0.
  - All sync, debounce and pointer state is 0.
- Reset asserted mid-operation flushes the FIFO and length immediately. A button held through reset release is not a press until it is released and pressed again.
- Latency: a button rising before edge k flips the debounced state at edge k+1+`db_cycles`. The FIFO write happens at edge k+2+`db_cycles`, and `cmd_valid` is high after that edge.
- A press shorter than `db_cycles` cycles at `s2` is ignored.
- `cmd_op` and `cmd_data` are driven combinationally from the FIFO head. They hold while `cmd_valid && !cmd_ready`.
- `buf_len`, `buf_full`, `buf_empty` and `err` update at the enqueue edge.

## Structure
- `keystroke_pkg`:
  - opcode constants `OP_ENTER`, `OP_DELETE`, `OP_CLEAR`, `OP_RUN`;
  - keystroke bit indices `KS_ENTER`=8, `KS_DELETE`=9, `KS_CLEAR`=10, `KS_RUN`=11.
- Sub-module `key_debounce`, parameterized by `db_cycles`, instantiated four times. Ports: `clk_raw`, `rst_n`, `din`, `level`, `press`.
- FIFO and arbitration stay inline in `keystroke_ctrl`.

## Test plan
- Reset, then keystroke=0x082 with bit 8 high for 5 cycles (`db_cycles`=4) → exactly one entry {OP_ENTER, 0x82}, `buf_len`=1. `cmd_valid` rises 6 edges after the input edge.
- Bit 8 glitch of 3 cycles → no command, `err`=0.
- `cmd_ready`=0 and 5 ENTER presses → 4 entries queued, 5th dropped, `err`=1, `buf_len`=4. Then `cmd_ready`=1 → four pops in order, `cmd_valid`=0.
- 33 ENTER presses with `cmd_ready`=1 → `buf_len`=32, `buf_full`=1, 33rd dropped, `err`=1. Then CLEAR → `buf_len`=0, `err`=0, OP_CLEAR issued.
- DELETE at `buf_len`=0 → dropped, `err`=1. Bits 8 and 10 rising together → only OP_CLEAR queued, `err`=1.
- `rst_n` pulsed low with 3 entries queued → `cmd_valid`=0 and `buf_len`=0 asynchronously. Bit 8 held across reset release → no command until it is re-pressed.
